// File: rtl/nn_resample_ctrl.sv
// nn_resample_ctrl: nearest-neighbour pitch-scaling sequencer driving a multiplier and two frame buffers.
// Optional NN_RESAMPLE_ZERO_PAD_EN: samples that overflow the frame end are written as zero.
module nn_resample_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int MULT_LATENCY = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [16:0]       ratio,
  output logic [ADDR_W:0]   mult_a,
  output logic [16:0]       mult_b,
  input  logic [ADDR_W:0]   mult_p,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_we,
  output logic              busy,
  output logic              done
);
  localparam int L = MULT_LATENCY + RD_LATENCY;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [L:1] v_d;
  logic [ADDR_W-1:0] idx_d [1:L];
  logic last;
  assign last = &mult_a[ADDR_W-1:0];
  // Truncating to ADDR_W bits gives the modulo-frame wrap for free.
  assign src_addr = ADDR_W'(mult_p);
  assign dst_we = v_d[L];
  assign dst_addr = idx_d[L];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mult_a <= '0;
      mult_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      v_d <= '0;
      for (int k = 1; k <= L; k++) idx_d[k] <= '0;
    end else begin
      v_d <= {v_d[L-1:1], state == RUN};
      idx_d[1] <= mult_a[ADDR_W-1:0];
      for (int k = 2; k <= L; k++) idx_d[k] <= idx_d[k-1];
      case (state)
        IDLE: if (start) begin
          mult_b <= ratio;
          mult_a <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          mult_a <= last ? '0 : mult_a + (ADDR_W+1)'(1);
          if (last) state <= DRAIN;
        end
        // Leave once the final index is the only one left, i.e. being written now.
        DRAIN: if (~|v_d[L-1:1]) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef NN_RESAMPLE_ZERO_PAD_EN
  logic [RD_LATENCY:1] o_d;
  always_ff @(posedge clk) begin
    if (reset) o_d <= '0;
    else begin
      o_d[1] <= mult_p[ADDR_W];
      for (int k = 2; k <= RD_LATENCY; k++) o_d[k] <= o_d[k-1];
    end
  end
  assign dst_data = (v_d[L] && !o_d[RD_LATENCY]) ? src_data : '0;
`else
  assign dst_data = v_d[L] ? src_data : '0;
`endif
endmodule

// File: tb/tb_nn_resample_ctrl.sv
// tb_nn_resample_ctrl: randomized frame tests against a floor(i*ratio) reference model.
module tb_nn_resample_ctrl;
  localparam int N = 2048;
  localparam int LAT = 2;
  logic clk = 0, reset = 1, start = 0;
  logic [16:0] ratio = '0;
  logic [11:0] mult_a, mult_p = '0;
  logic [16:0] mult_b;
  logic [10:0] src_addr, dst_addr;
  logic [15:0] src_data = '0, dst_data;
  logic dst_we, busy, done;
  logic [15:0] src_mem [N];
  logic [15:0] dst_mem [N];
  int checks = 0, failures = 0, wcount = 0, order_err = 0;

  nn_resample_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ratio(ratio),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .src_addr(src_addr), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [28:0] prod;
  assign prod = mult_a * mult_b;
  always @(posedge clk) begin
    mult_p <= prod[27:16];
    src_data <= src_mem[src_addr];
  end

  always @(negedge clk) if (dst_we) begin
    if (int'(dst_addr) != wcount) order_err++;
    dst_mem[dst_addr] = dst_data;
    wcount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int i, input logic [16:0] r);
    longint p = (longint'(i) * longint'(r)) >>> 16;
`ifdef NN_RESAMPLE_ZERO_PAD_EN
    if (p >= N) return 16'h0;
`endif
    return src_mem[int'(p % N)];
  endfunction

  task automatic run_frame(input logic [16:0] r, input int kind);
    int k = 0, first_k = -1, done_k = -1, bad = 0;
    wcount = 0;
    order_err = 0;
    for (int i = 0; i < N; i++) dst_mem[i] = ~model(i, r);
    @(negedge clk);
    ratio = r;
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
    while (done_k < 0 && k < 3000) begin
      if (dst_we && first_k < 0) first_k = k;
      if (done) done_k = k;
      if (kind == 1 && k == 100) begin ratio = 17'h08000; start = 1; end
      if (kind == 1 && k == 101) start = 0;
      if (kind == 2 && k == 10) ratio = 17'h18000;
      if (k == 500) check("mult_b_held", mult_b, r);
      if (k == 1000 && !busy) bad++;
      @(negedge clk);
      k++;
    end
    check("busy_mid_frame", bad, 0);
    check("first_we_cycle", first_k, LAT);
    check("done_cycle", done_k, N + LAT);
    check("write_count", wcount, N);
    check("write_order", order_err, 0);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (dst_mem[i] !== model(i, r)) begin
      bad++;
      if (bad <= 4) check($sformatf("dst[%0d]", i), dst_mem[i], model(i, r));
    end
    check("frame_mismatches", bad, 0);
    ratio = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_mem[i] = 16'(i);
    repeat (4) @(negedge clk);
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", dst_we, 0);
    check("rst_mult_b", mult_b, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_dst_data", dst_data, 0);
    run_frame(17'h10000, 0);
    check("identity_7", dst_mem[7], 7);
    check("identity_2047", dst_mem[2047], 2047);
    for (int i = 0; i < N; i++) src_mem[i] = 16'($urandom);
    run_frame(17'h08000, 0);
    check("half_2047", dst_mem[2047], src_mem[1023]);
    check("half_1", dst_mem[1], src_mem[0]);
    run_frame(17'h18000, 0);
    check("ovf_1365", dst_mem[1365], src_mem[2047]);
`ifdef NN_RESAMPLE_ZERO_PAD_EN
    check("ovf_1366", dst_mem[1366], 0);
    check("ovf_2047", dst_mem[2047], 0);
`else
    check("ovf_1366", dst_mem[1366], src_mem[1]);
    check("ovf_2047", dst_mem[2047], src_mem[1022]);
`endif
    run_frame(17'h10000, 1);
    @(negedge clk);
    ratio = 17'h10000;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (500) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_we", dst_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 0;
    begin
      int seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (done || dst_we || busy) seen++;
      end
      check("midrst_quiet", seen, 0);
    end
    run_frame(17'h0C000, 0);
    run_frame(17'h10000, 2);
    run_frame(17'h00000, 0);
    check("zero_ratio", dst_mem[1500], src_mem[0]);
    run_frame(17'h1FFFF, 0);
    repeat (2) begin
      for (int i = 0; i < N; i++) src_mem[i] = 16'($urandom);
      run_frame(17'($urandom_range(0, 17'h1FFFF)), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
